// File: rtl/hash_sys_pkg.sv
// Shared types and constants for the hash-core memory arbiter.
// Holds the FSM state enum, default bus widths and the watchdog counter width.
package hash_sys_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY,
        RELEASE
    } arb_state_t;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned WDOG_W     = 24;
    // Wide enough for the largest supported core count (8).
    localparam int unsigned IDX_W      = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after pointer, wrapping.
// Returns whether any request is set, its index and its one-hot form.
module rr_pick
    import hash_sys_pkg::*;
#(
    parameter int unsigned NUM_CORES = 2
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     pointer,
    output logic                 valid,
    output logic [IDX_W-1:0]     index,
    output logic [NUM_CORES-1:0] onehot
);

    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            automatic int unsigned c = (32'(pointer) + k) % NUM_CORES;
            if (!valid && ((req >> c) & NUM_CORES'(1)) != '0) begin
                valid  = 1'b1;
                index  = IDX_W'(c);
                onehot = NUM_CORES'(1) << c;
            end
        end
    end

endmodule

// File: rtl/hash_core_mem_arbiter.sv
// Grants a single-port memory to one hash core per job: launch, mux its bus, detect
// completion (or watchdog abort), release, then pick the next requester round-robin.
module hash_core_mem_arbiter
    import hash_sys_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 2,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CORES-1:0]        req,
    output logic [NUM_CORES-1:0]        grant,
    output logic [NUM_CORES-1:0]        job_done,
    output logic [NUM_CORES-1:0]        job_timeout,
    output logic [NUM_CORES-1:0]        core_start,
    input  logic [NUM_CORES-1:0]        core_done,
    input  logic [NUM_CORES-1:0]        core_mem_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_mem_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_mem_write_data,
    output logic                        mem_clk,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_write_data
);

    arb_state_t            state_q, state_d;
    logic [NUM_CORES-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  armed_q, armed_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic [NUM_CORES-1:0]  start_q, start_d;
    logic [NUM_CORES-1:0]  done_q, done_d;
    logic [NUM_CORES-1:0]  tmo_q, tmo_d;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_index;
    logic [NUM_CORES-1:0]  pick_onehot;
    logic                  owner_done;
    logic [IDX_W:0]        idx_inc;

    rr_pick #(
        .NUM_CORES (NUM_CORES)
    ) u_rr_pick (
        .req     (req),
        .pointer (ptr_q),
        .valid   (pick_valid),
        .index   (pick_index),
        .onehot  (pick_onehot)
    );

    assign owner_done = |(core_done & grant_q);
    assign idx_inc    = {1'b0, idx_q} + (IDX_W + 1)'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        armed_d = armed_q;
        wdog_d  = wdog_q;
        start_d = '0;
        done_d  = '0;
        tmo_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    idx_d   = pick_index;
                    start_d = pick_onehot;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                wdog_d  = '0;
                armed_d = 1'b0;
                state_d = BUSY;
            end
            BUSY: begin
                // A done level only counts once it has been seen low during this job.
                if (armed_q && owner_done) begin
                    done_d  = grant_q;
                    state_d = RELEASE;
                end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = grant_q;
                    state_d = RELEASE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                    if (!owner_done) begin
                        armed_d = 1'b1;
                    end
                end
            end
            RELEASE: begin
                grant_d = '0;
                ptr_d   = (idx_inc == (IDX_W + 1)'(NUM_CORES)) ? '0 : idx_inc[IDX_W-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            armed_q <= 1'b0;
            wdog_q  <= '0;
            start_q <= '0;
            done_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            armed_q <= armed_d;
            wdog_q  <= wdog_d;
            start_q <= start_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (state_q == LAUNCH || state_q == BUSY) begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (grant_q[i]) begin
                    mem_we         = core_mem_we[i];
                    mem_addr       = core_mem_addr[i*ADDR_W +: ADDR_W];
                    mem_write_data = core_mem_write_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign mem_clk     = clk;
    assign grant       = grant_q;
    assign core_start  = start_q;
    assign job_done    = done_q;
    assign job_timeout = tmo_q;

endmodule

// File: tb/tb_hash_core_mem_arbiter.sv
// Self-checking bench for hash_core_mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a job-level reference model.
module tb_hash_core_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int T  = 4096;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [N-1:0]    job_done;
    logic [N-1:0]    job_timeout;
    logic [N-1:0]    core_start;
    logic [N-1:0]    core_done;
    logic [N-1:0]    core_mem_we;
    logic [N*AW-1:0] core_mem_addr;
    logic [N*DW-1:0] core_mem_write_data;
    logic            mem_clk;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_write_data;

    hash_core_mem_arbiter #(
        .NUM_CORES      (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .req                 (req),
        .grant               (grant),
        .job_done            (job_done),
        .job_timeout         (job_timeout),
        .core_start          (core_start),
        .core_done           (core_done),
        .core_mem_we         (core_mem_we),
        .core_mem_addr       (core_mem_addr),
        .core_mem_write_data (core_mem_write_data),
        .mem_clk             (mem_clk),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_write_data      (mem_write_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: current job owner, its age in cycles since grant, and its outcome.
    int m_owner;    // -1 when no job
    int m_age;      // 0 = start cycle, k = k-th working cycle
    int m_lows;     // working cycles in which owner's done was low
    int m_outcome;  // 0 running, 1 finished, 2 aborted (shown for one cycle)
    int m_ptr;

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_lows = 0; m_outcome = 0; m_ptr = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
        if (m_owner < 0) begin
            bit found = 0;
            for (int k = 0; k < N; k++) begin
                int c = (m_ptr + k) % N;
                if (!found && r[c]) begin
                    found = 1; m_owner = c; m_age = 0; m_outcome = 0;
                end
            end
        end else if (m_outcome != 0) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
            m_outcome = 0;
        end else if (m_age == 0) begin
            m_age = 1; m_lows = 0;
        end else if (m_lows > 0 && d[m_owner]) begin
            m_outcome = 1;
        end else if (m_age == T) begin
            m_outcome = 2;
        end else begin
            m_age++;
            if (!d[m_owner]) m_lows++;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] oh;
        bit active;
        oh = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        active = (m_owner >= 0) && (m_outcome == 0);
        check_eq("grant", 64'(grant), 64'(oh));
        check_eq("core_start", 64'(core_start), 64'((m_owner >= 0 && m_age == 0 && active) ? oh : '0));
        check_eq("job_done", 64'(job_done), 64'((m_outcome == 1) ? oh : '0));
        check_eq("job_timeout", 64'(job_timeout), 64'((m_outcome == 2) ? oh : '0));
        check_eq("mem_we", 64'(mem_we), active ? 64'(core_mem_we[m_owner]) : 64'(0));
        check_eq("mem_addr", 64'(mem_addr),
                 active ? 64'(core_mem_addr[m_owner*AW +: AW]) : 64'(0));
        check_eq("mem_write_data", 64'(mem_write_data),
                 active ? 64'(core_mem_write_data[m_owner*DW +: DW]) : 64'(0));
    endtask

    // Core behaviour: after a start, done stays high hi_cfg cycles, low lo_cfg cycles, then high.
    int hi_cfg[N], lo_cfg[N], hi_cnt[N], lo_cnt[N];
    bit rand_mode = 0;
    int cyc = 0;
    int last_done = -100000, last_tmo = -100000;
    int starts[$];
    int start_cyc[$];

    task automatic drive_next();
        for (int i = 0; i < N; i++) begin
            if (core_start[i]) begin
                if (rand_mode) begin
                    hi_cfg[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
                    lo_cfg[i] = int'($urandom_range(2, 30));
                end
                hi_cnt[i] = hi_cfg[i];
                lo_cnt[i] = lo_cfg[i];
            end
            if (hi_cnt[i] > 0) begin
                core_done[i] = 1'b1; hi_cnt[i]--;
            end else if (lo_cnt[i] > 0) begin
                core_done[i] = 1'b0; lo_cnt[i]--;
            end else begin
                core_done[i] = 1'b1;
            end
            core_mem_addr[i*AW +: AW]       = AW'($urandom);
            core_mem_write_data[i*DW +: DW] = $urandom;
        end
        core_mem_we = N'($urandom);
        if (rand_mode) req = N'($urandom);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(req, core_done);
        cyc++;
        #1;
        check_all();
        for (int i = 0; i < N; i++) begin
            if (core_start[i]) begin
                starts.push_back(i);
                start_cyc.push_back(cyc);
            end
        end
        if (job_done != '0) last_done = cyc;
        if (job_timeout != '0) last_tmo = cyc;
        drive_next();
    endtask

    initial begin
        req = '0;
        core_done = '0;
        core_mem_we = '0;
        core_mem_addr = '0;
        core_mem_write_data = '0;
        for (int i = 0; i < N; i++) begin
            hi_cfg[i] = 0; lo_cfg[i] = 20; hi_cnt[i] = 0; lo_cnt[i] = 0;
        end
        model_reset();
        #1 reset_n = 1'b0;
        #2 check_all();
        #9 reset_n = 1'b1;

        // Single job on core 0, done rises in working cycle 200.
        lo_cfg[0] = 200;
        starts.delete(); start_cyc.delete();
        req = 2'b01;
        cycle();
        req = 2'b00;
        repeat (215) cycle();
        check_eq("t1_done_latency", 64'(last_done - start_cyc[0]), 64'(201));

        // Both requesting: strict alternation, starting with core 1 (core 0 just served).
        lo_cfg[0] = 50; lo_cfg[1] = 50;
        starts.delete(); start_cyc.delete();
        req = 2'b11;
        for (int k = 0; k < 400 && starts.size() < 4; k++) cycle();
        check_eq("t2_nstarts", 64'(starts.size()), 64'(4));
        check_eq("t2_first", 64'(starts[0]), 64'(1));
        for (int k = 1; k < 4; k++) check_eq("t2_alternate", 64'(starts[k]), 64'(1 - starts[k-1]));
        req = 2'b00;
        repeat (120) cycle();

        // Stale done on core 1: high 30 cycles, low 10, then high again.
        hi_cfg[1] = 30; lo_cfg[1] = 10;
        starts.delete(); start_cyc.delete();
        req = 2'b10;
        cycle();
        req = 2'b00;
        repeat (80) cycle();
        check_eq("t3_stale_latency", 64'(last_done - start_cyc[0]), 64'(41));

        // Done stuck high on core 1: watchdog abort after T working cycles.
        hi_cfg[1] = 1000000; lo_cfg[1] = 0;
        starts.delete(); start_cyc.delete();
        req = 2'b10;
        cycle();
        req = 2'b00;
        repeat (T + 10) cycle();
        check_eq("t4_stuck_timeout", 64'(last_tmo - start_cyc[0]), 64'(T + 1));

        // Core 0 never finishes while core 1 waits: abort, then core 1 is granted.
        hi_cfg[0] = 0; lo_cfg[0] = 1000000;
        hi_cfg[1] = 0; lo_cfg[1] = 5;
        starts.delete(); start_cyc.delete();
        req = 2'b11;
        cycle();
        req = 2'b10;
        repeat (T + 20) cycle();
        check_eq("t5_first_owner", 64'(starts[0]), 64'(0));
        check_eq("t5_dead_timeout", 64'(last_tmo - start_cyc[0]), 64'(T + 1));
        check_eq("t5_next_owner", 64'(starts[1]), 64'(1));
        check_eq("t5_next_gap", 64'(start_cyc[1] - last_tmo), 64'(2));
        req = 2'b00;
        lo_cfg[0] = 20;
        repeat (60) cycle();

        // Random traffic.
        rand_mode = 1;
        repeat (3000) cycle();
        rand_mode = 0;
        req = 2'b00;
        repeat (80) cycle();

        // Asynchronous reset in the middle of a job, then pointer back at core 0.
        lo_cfg[0] = 100;
        req = 2'b01;
        repeat (20) cycle();
        req = 2'b00;
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        lo_cfg[0] = 10; lo_cfg[1] = 10; hi_cfg[0] = 0; hi_cfg[1] = 0;
        starts.delete(); start_cyc.delete();
        req = 2'b11;
        repeat (5) cycle();
        check_eq("t7_post_reset_owner", 64'(starts[0]), 64'(0));
        req = 2'b00;
        repeat (60) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
